// File: rtl/seq_word_adder.sv
// Multi-cycle W-bit adder/subtractor that reuses one 6-bit adder slice,
// processing one slice per clock LSB first with a registered inter-slice carry.

module six_bit_full_adder (
    input  logic [5:0] i_a,
    input  logic [5:0] i_b,
    input  logic       i_c,
    output logic [5:0] o_sum,
    output logic       o_c
);
    assign {o_c, o_sum} = 7'(i_a) + 7'(i_b) + 7'(i_c);
endmodule

module seq_word_adder #(
    parameter int SLICES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6*SLICES-1:0] a,
    input  logic [6*SLICES-1:0] b,
    input  logic                sub,
    input  logic                c_in,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [6*SLICES-1:0] sum,
    output logic                c_out,
    output logic                overflow
);
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [IW-1:0]            r_idx;
    logic                     r_carry;
    logic                     r_overflow;
    logic [SLICES-1:0][5:0]   r_a;
    logic [SLICES-1:0][5:0]   r_b;
    logic [SLICES-1:0][5:0]   r_sum;

    logic [5:0]               w_slice_sum;
    logic                     w_slice_c;
    logic                     w_last;
    logic                     w_accept;
    logic                     w_step;

    assign w_last   = (r_idx == IW'(SLICES - 1));
    assign w_accept = (r_state == S_IDLE) && in_valid && !abort;
    assign w_step   = (r_state == S_RUN) && !abort;

    six_bit_full_adder u_slice (
        .i_a   (r_a[r_idx]),
        .i_b   (r_b[r_idx]),
        .i_c   (r_carry),
        .o_sum (w_slice_sum),
        .o_c   (w_slice_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // abort outranks both slice completion and out_ready.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state; no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid && !abort) w_next_state = S_RUN;
            S_RUN: begin
                if (abort)       w_next_state = S_IDLE;
                else if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (abort || out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
        end else if (w_accept) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum[r_idx] <= w_slice_sum;
            r_carry      <= w_slice_c;
            r_idx        <= r_idx + 1'b1;
            // b is already inverted for subtract, so one rule covers both ops.
            if (w_last) begin
                r_overflow <= (r_a[SLICES-1][5] == r_b[SLICES-1][5]) &&
                              (w_slice_sum[5] != r_a[SLICES-1][5]);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign c_out     = r_carry;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_word_adder.sv
// Directed bench for seq_word_adder (SLICES=4): vector table plus
// backpressure, abort and asynchronous-reset sequences.

module tb_seq_word_adder;
    localparam int W = 24;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          c_in;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    seq_word_adder #(.SLICES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic ts, input logic tc);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        sub      = ts;
        c_in     = tc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        c_in     = 1'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        int lat;
        start_op(v.a, v.b, v.sub, v.cin);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " sum"}, 32'(sum), 32'(v.exp_sum));
        check({tag, " c_out"}, 32'(c_out), 32'(v.exp_cout));
        check({tag, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic watch_quiet(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({tag, " no out_valid"}, 32'(seen), 32'd0);
    endtask

    vec_t vecs [9];
    vec_t v;

    initial begin
        vecs[0] = '{24'h000001, 24'hFFFFFF, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[1] = '{24'h000005, 24'h000007, 1'b1, 1'b0, 24'hFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{24'h000007, 24'h000005, 1'b1, 1'b0, 24'h000002, 1'b1, 1'b0};
        vecs[3] = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
        vecs[4] = '{24'h800000, 24'h000001, 1'b1, 1'b0, 24'h7FFFFF, 1'b1, 1'b1};
        vecs[5] = '{24'h000000, 24'h000000, 1'b0, 1'b1, 24'h000001, 1'b0, 1'b0};
        vecs[6] = '{24'h000010, 24'h000010, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[7] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[8] = '{24'h123456, 24'h111111, 1'b0, 1'b0, 24'h234567, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        c_in      = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset c_out", 32'(c_out), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held while new requests are ignored.
        begin
            int lat;
            start_op(24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
            wait_done(lat);
            check("bp latency", 32'(lat), 32'd4);
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                a        = 24'h111111;
                b        = 24'h222222;
                sub      = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
                check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
                check($sformatf("bp%0d sum", i), 32'(sum), 32'h800000);
                check($sformatf("bp%0d c_out", i), 32'(c_out), 32'd0);
                check($sformatf("bp%0d overflow", i), 32'(overflow), 32'd1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check("bp release out_valid", 32'(out_valid), 32'd0);
            check("bp release in_ready", 32'(in_ready), 32'd1);
            watch_quiet("bp ignored request");
        end

        // Abort in the second RUN cycle.
        start_op(24'h0F0F0F, 24'h010101, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        watch_quiet("abort");
        v = '{24'h123456, 24'h111111, 1'b0, 1'b0, 24'h234567, 1'b0, 1'b0};
        apply(v, "post-abort");

        // Abort while idle with in_valid must not accept.
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        check("idle abort in_ready", 32'(in_ready), 32'd1);
        watch_quiet("idle abort");

        // Asynchronous reset between edges in mid-RUN.
        start_op(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst in_ready", 32'(in_ready), 32'd1);
        check("arst out_valid", 32'(out_valid), 32'd0);
        check("arst sum", 32'(sum), 32'd0);
        check("arst c_out", 32'(c_out), 32'd0);
        check("arst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{24'h00003F, 24'h000001, 1'b0, 1'b0, 24'h000040, 1'b0, 1'b0};
        apply(v, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_word_adder.md
# seq_word_adder

Multi-cycle wide adder/subtractor that time-multiplexes a single `SixBitFullAdder` slice across a `6*SLICES`-bit operand, one 6-bit slice per clock, LSB slice first, with a registered carry between slices. It sits between the synth's control logic (phase/envelope/pitch arithmetic) and the shared 6-bit adder datapath. It gives wide arithmetic at the area cost of one adder. Operands enter and results leave through valid/ready handshakes.

## Interface
- `SLICES`, default 4: number of 6-bit slices; operand width `W = 6*SLICES` (24 by default); legal range 2..16.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept; equals `state==IDLE`.
- `a`  in  W  first operand.
- `b`  in  W  second operand.
- `sub`  in  1  1 = compute `a - b` (two's complement), 0 = `a + b + c_in`.
- `c_in`  in  1  carry-in for add; ignored when `sub=1`.
- `abort`  in  1  synchronous cancel of the in-flight operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `sum`  out  W  result.
- `c_out`  out  1  carry out of bit W-1. For subtract, 1 = no borrow.
- `overflow`  out  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE (2-bit encoding). Slice counter `idx`, width `$clog2(SLICES)`.
- IDLE: `in_ready=1`. On `in_valid & ~abort`, capture:
  - `a` into `a_r`.
  - `sub ? ~b : b` into `b_r`.
  - `sub ? 1 : c_in` into `carry_r`.
  - `idx=0`; go to RUN.
  - `in_valid & abort` in IDLE: no accept; stay in IDLE.
- RUN: the single adder instance sees `a_r[6*idx+:6]`, `b_r[6*idx+:6]` and `carry_r`. Each cycle:
  - Write the slice sum into `sum_r[6*idx+:6]`.
  - Update `carry_r` with the adder's `c_out`.
  - Increment `idx`.
  - When `idx==SLICES-1`, go to DONE after this cycle's write.
- DONE: `out_valid=1`. `sum`, `c_out` and `overflow` are held stable. On `out_ready`, go to IDLE. `out_valid` drops the next cycle.
- `overflow = (a_r[W-1] == b_r[W-1]) & (sum_r[W-1] != a_r[W-1])`, using the already-inverted `b_r`. Registered; valid only when `out_valid=1`.
- `c_out` is `carry_r` after the final slice.
- `abort` in RUN or DONE: go to IDLE on the next edge. No `out_valid` pulse follows in RUN; in DONE `out_valid` drops. `abort` has priority over `out_ready` and over slice completion.
- No operand changes are observed after acceptance. `a`/`b`/`sub`/`c_in` may change freely while busy.
- `in_valid` while not in IDLE is ignored. It is not queued.
- Arithmetic is modulo 2^W. No saturation.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - state=IDLE, `idx=0`, `carry_r=0`.
  - `a_r`, `b_r`, `sum_r` = 0.
  - `in_ready=1`, `out_valid=0`, `sum=0`, `c_out=0`, `overflow=0`.
- Reset mid-RUN/DONE: the operation is discarded and all outputs take reset values immediately.
- Accept edge T0. Slice k is computed in cycle T0+1+k. `out_valid` rises after edge T0+SLICES (latency `SLICES` cycles; 4 by default).
- With `out_ready` tied high, `out_valid` is a 1-cycle pulse and the minimum issue interval is `SLICES+2` cycles.
- `in_ready`, `out_valid`, `sum`, `c_out` and `overflow` are all register-driven. No combinational path exists from inputs to outputs.
- Critical path: one 6-bit ripple plus the slice mux. It is independent of `SLICES`.

## Test plan
- Add with wrap, SLICES=4: `a=0x000001`, `b=0xFFFFFF`, `c_in=0` -> `sum=0x000000`, `c_out=1`, `overflow=0`. `out_valid` rises exactly 4 cycles after the accept edge.
- Subtract with borrow: `a=0x000005`, `b=0x000007`, `sub=1` -> `sum=0xFFFFFE`, `c_out=0`, `overflow=0`. Then `a=0x000007`, `b=0x000005` -> `sum=0x000002`, `c_out=1`.
- Signed overflow: `0x7FFFFF + 0x000001` -> `sum=0x800000`, `overflow=1`, `c_out=0`. Then `0x800000 - 0x000001` (sub) -> `0x7FFFFF`, `overflow=1`.
- Backpressure: hold `out_ready=0` for 3 cycles in DONE while pulsing `in_valid` with new operands. Required: `sum` and flags stable, `in_ready=0`, second request ignored. `out_ready=1` -> IDLE next cycle.
- Abort: assert `abort` in the second RUN cycle. Required: IDLE next edge, no `out_valid`. The following op `0x123456 + 0x111111` -> `0x234567`.
- Async reset: drop `rst_n` mid-RUN between clock edges. Required: outputs at reset values immediately. After release, `0x00003F + 0x000001` -> `0x000040`, checking the carry across a slice boundary.
